// File: rtl/bundle_issue_ctrl_if.sv
// Bundle issue controller port bundle.
// Fetch, issue, redirect and status signals in one place.
interface bundle_issue_ctrl_if #(
    parameter int NUM_FU = 4
);
    logic                   fetch_req;
    logic [63:0]            fetch_addr;
    logic                   fetch_valid;
    logic [NUM_FU*32-1:0]   fetch_bundle;
    logic [NUM_FU*32-1:0]   fu_instruction;
    logic [NUM_FU-1:0]      fu_ready;
    logic [63:0]            fu_bundle_addr;
    logic [NUM_FU-1:0]      fu_working;
    logic                   stall_in;
    logic                   fu_do_stall;
    logic                   redirect_valid;
    logic [63:0]            redirect_addr;
    logic [31:0]            bundle_count;
    logic                   timeout_err;

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_valid,
        input  fetch_bundle,
        output fu_instruction,
        output fu_ready,
        output fu_bundle_addr,
        input  fu_working,
        input  stall_in,
        output fu_do_stall,
        input  redirect_valid,
        input  redirect_addr,
        output bundle_count,
        output timeout_err
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_bundle,
        output fetch_valid,
        input  fu_instruction,
        input  fu_ready,
        input  fu_bundle_addr,
        output fu_working,
        output stall_in,
        input  fu_do_stall,
        output redirect_valid,
        output redirect_addr,
        input  bundle_count,
        input  timeout_err
    );
endinterface

// File: rtl/bundle_issue_ctrl.sv
// VLIW front-end sequencer: fetch one bundle, issue to all units,
// wait for the units to drain, then advance or redirect the PC.
module bundle_issue_ctrl #(
    parameter int          NUM_FU        = 4,
    parameter logic [63:0] RESET_PC      = 64'h0,
    parameter int          DRAIN_TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 rst,
    bundle_issue_ctrl_if.master bus
);

    localparam int BW     = NUM_FU * 32;
    localparam int STRIDE = NUM_FU * 4;
    localparam int TW     = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [63:0]   STRIDE64   = 64'(STRIDE);
    localparam logic [63:0]   ALIGN_MASK = ~(STRIDE64 - 64'd1);
    localparam logic [TW-1:0] TIMEOUT    = TW'(DRAIN_TIMEOUT);
    localparam logic [TW-1:0] TIMEOUT_M1 = TW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        FETCH,
        WAIT_FETCH,
        ISSUE,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_n;

    logic [63:0]     pc;
    logic [63:0]     redir_tgt;
    logic            pending;
    logic [BW-1:0]   bundle_q;
    logic [1:0]      settle;
    logic [TW-1:0]   drain_cnt;

    logic            do_fetch;
    logic            do_latch;
    logic            do_issue;
    logic            do_retire;
    logic [63:0]     redir_aligned;
    logic [63:0]     next_pc;

    assign redir_aligned = bus.redirect_addr & ALIGN_MASK;

    // Next-state decode and the one-cycle action strobes.
    always_comb begin
        state_n   = state;
        do_fetch  = 1'b0;
        do_latch  = 1'b0;
        do_issue  = 1'b0;
        do_retire = 1'b0;
        unique case (state)
            FETCH: begin
                if (!bus.stall_in) begin
                    do_fetch = 1'b1;
                    state_n  = WAIT_FETCH;
                end
            end
            WAIT_FETCH: begin
                if (bus.fetch_valid) begin
                    do_latch = 1'b1;
                    state_n  = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.stall_in) begin
                    do_issue = 1'b1;
                    state_n  = DRAIN;
                end
            end
            DRAIN: begin
                if (settle == 2'd0 && bus.fu_working == '0) begin
                    do_retire = 1'b1;
                    state_n   = FETCH;
                end
            end
        endcase
    end

    // Address of the following bundle; a same-cycle redirect wins.
    always_comb begin
        next_pc = pc + STRIDE64;
        if (bus.redirect_valid) begin
            next_pc = redir_aligned;
        end else if (pending) begin
            next_pc = redir_tgt;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    // Single-cycle fetch request with the current bundle address.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.fetch_req  <= 1'b0;
            bus.fetch_addr <= 64'h0;
        end else begin
            bus.fetch_req <= do_fetch;
            if (do_fetch) begin
                bus.fetch_addr <= pc;
            end
        end
    end

    // Capture the returned bundle; valid is ignored outside WAIT_FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_q <= '0;
        end else if (do_latch) begin
            bundle_q <= bus.fetch_bundle;
        end
    end

    // Broadcast slots; instructions hold until the next issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.fu_ready       <= '0;
            bus.fu_instruction <= '0;
            bus.fu_bundle_addr <= 64'h0;
        end else begin
            bus.fu_ready <= {NUM_FU{do_issue}};
            if (do_issue) begin
                bus.fu_instruction <= bundle_q;
                bus.fu_bundle_addr <= pc;
            end
        end
    end

    // Settle delay masks the units' registered busy-flag lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle    <= 2'd0;
            drain_cnt <= '0;
        end else if (do_issue) begin
            settle    <= 2'd2;
            drain_cnt <= '0;
        end else if (state == DRAIN) begin
            if (settle != 2'd0) begin
                settle <= settle - 2'd1;
            end
            if (!do_retire && drain_cnt != TIMEOUT) begin
                drain_cnt <= drain_cnt + 1'b1;
            end
        end
    end

    // Sticky error once a drain has lasted DRAIN_TIMEOUT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.timeout_err <= 1'b0;
        end else if (state == DRAIN && !do_retire
                     && drain_cnt == TIMEOUT_M1) begin
            bus.timeout_err <= 1'b1;
        end
    end

    // PC advance on retire and latching of pending redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            pending   <= 1'b0;
            redir_tgt <= 64'h0;
        end else if (do_retire) begin
            pc      <= next_pc;
            pending <= 1'b0;
        end else if (bus.redirect_valid) begin
            pending   <= 1'b1;
            redir_tgt <= redir_aligned;
        end
    end

    // Retired bundle counter, free-running wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.bundle_count <= 32'h0;
        end else if (do_retire) begin
            bus.bundle_count <= bus.bundle_count + 32'd1;
        end
    end

    // Registered stall fan-out to every unit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.fu_do_stall <= 1'b0;
        end else begin
            bus.fu_do_stall <= bus.stall_in;
        end
    end

endmodule

// File: tb/tb_bundle_issue_ctrl.sv
// Bench for bundle_issue_ctrl: directed steps plus random bundles
// checked against a bundle-level address/count model.
module tb_bundle_issue_ctrl;

    localparam int          NUM_FU = 4;
    localparam logic [63:0] RPC    = 64'h1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bundle_issue_ctrl_if #(.NUM_FU(NUM_FU)) bus ();

    bundle_issue_ctrl #(
        .NUM_FU       (NUM_FU),
        .RESET_PC     (RPC),
        .DRAIN_TIMEOUT(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_err;
    int          fetch_wait;
    logic [63:0] fetched_addr;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        bus.fetch_valid    = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_fetch_req", bus.fetch_req, 0);
        chk("rst_fetch_addr", bus.fetch_addr, 0);
        chk("rst_fu_ready", bus.fu_ready, 0);
        chk("rst_fu_instr", bus.fu_instruction, 0);
        chk("rst_fu_baddr", bus.fu_bundle_addr, 0);
        chk("rst_do_stall", bus.fu_do_stall, 0);
        chk("rst_count", bus.bundle_count, 0);
        chk("rst_timeout", bus.timeout_err, 0);
    endtask

    // One whole bundle: fetch, memory reply after lat cycles, issue,
    // units busy for hold cycles, optional redirects, then drain.
    task automatic run_bundle(input logic [127:0] bun, input int lat,
                              input int hold, input int nredir,
                              input logic [63:0] ra,
                              input logic [63:0] rb,
                              input bit spurious);
        int          n;
        logic [63:0] last_r;
        last_r = 64'h0;
        n = 0;
        step();
        while (bus.fetch_req !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        fetch_wait = n;
        if (n >= 60) begin
            chk("fetch_req_seen", bus.fetch_req, 1);
            return;
        end
        chk("fetch_addr", bus.fetch_addr, exp_pc);
        chk("count_at_fetch", bus.bundle_count, exp_cnt);
        chk("timeout_sticky", bus.timeout_err, exp_err);
        fetched_addr = bus.fetch_addr;
        for (int i = 0; i < lat; i++) begin
            step();
            if (i == 0) chk("fetch_req_pulse", bus.fetch_req, 0);
        end
        bus.fetch_bundle = bun;
        bus.fetch_valid  = 1'b1;
        step();
        if (lat == 0) chk("fetch_req_pulse", bus.fetch_req, 0);
        n = 0;
        while (bus.fu_ready === 4'b0000 && n < 60) begin
            step();
            n++;
        end
        chk("fu_ready_val", bus.fu_ready, 4'hF);
        if (n >= 60) return;
        chk("fu_instr", bus.fu_instruction, bun);
        chk("fu_baddr", bus.fu_bundle_addr, fetched_addr);
        step();
        chk("fu_ready_width", bus.fu_ready, 0);
        bus.fu_working = 4'($urandom_range(1, 15));
        if (nredir > 0) begin
            bus.redirect_addr  = ra;
            bus.redirect_valid = 1'b1;
            last_r = ra;
        end
        if (spurious) begin
            bus.fetch_bundle = ~bun;
            bus.fetch_valid  = 1'b1;
        end
        for (int i = 1; i < hold; i++) begin
            step();
            chk("instr_stable", bus.fu_instruction, bun);
            if (hold >= 260 && i == 100)
                chk("timeout_early", bus.timeout_err, exp_err);
            if (hold >= 260 && i == hold - 1) begin
                exp_err = 1'b1;
                chk("timeout_set", bus.timeout_err, exp_err);
            end
        end
        step();
        bus.fu_working = 4'b0000;
        if (nredir > 1) begin
            bus.redirect_addr  = rb;
            bus.redirect_valid = 1'b1;
            last_r = rb;
        end
        chk("instr_stable_exit", bus.fu_instruction, bun);
        exp_cnt = exp_cnt + 32'd1;
        if (nredir > 0) exp_pc = last_r & ~64'hF;
        else            exp_pc = exp_pc + 64'd16;
    endtask

    // Hold stall_in in FETCH; fetch_req stays low, do_stall lags.
    task automatic stall_fetch(input int ncyc);
        step();
        bus.stall_in = 1'b1;
        chk("stall_req0", bus.fetch_req, 0);
        chk("do_stall_lag", bus.fu_do_stall, 0);
        for (int i = 1; i < ncyc; i++) begin
            step();
            chk("stall_req0", bus.fetch_req, 0);
            chk("do_stall_hi", bus.fu_do_stall, 1);
        end
        step();
        bus.stall_in = 1'b0;
        chk("stall_rel_req0", bus.fetch_req, 0);
        chk("do_stall_tail", bus.fu_do_stall, 1);
    endtask

    function automatic logic [127:0] rnd_bundle();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] b0;
        int           n;
        b0 = {32'hDEADBEEF, 32'h0000003F, 32'h12345678, 32'h00000001};
        bus.fetch_valid    = 1'b0;
        bus.fetch_bundle   = '0;
        bus.fu_working     = '0;
        bus.stall_in       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 64'h0;
        exp_pc  = RPC;
        exp_cnt = 32'h0;
        exp_err = 1'b0;
        fetch_wait = 0;
        fetched_addr = 64'h0;

        rst = 1'b1;
        step();
        step();
        check_reset_values();
        rst = 1'b0;

        run_bundle(b0, 2, 3, 0, 64'h0, 64'h0, 1'b0);
        chk("first_fetch_lat", fetch_wait, 0);
        chk("slot0", bus.fu_instruction[31:0], 32'h00000001);
        chk("slot1", bus.fu_instruction[63:32], 32'h12345678);
        chk("slot2", bus.fu_instruction[95:64], 32'h0000003F);
        chk("slot3", bus.fu_instruction[127:96], 32'hDEADBEEF);
        run_bundle(rnd_bundle(), 2, 3, 0, 64'h0, 64'h0, 1'b0);
        run_bundle(rnd_bundle(), 2, 3, 0, 64'h0, 64'h0, 1'b0);
        step();
        chk("count_after_3", bus.bundle_count, exp_cnt);

        run_bundle(rnd_bundle(), 2, 4, 1, 64'h2007, 64'h0, 1'b0);
        run_bundle(rnd_bundle(), 1, 4, 2, 64'h3000, 64'h4000, 1'b0);
        run_bundle(rnd_bundle(), 0, 2, 1,
                   64'hFFFF_FFFF_FFFF_FFF5, 64'h0, 1'b1);
        run_bundle(rnd_bundle(), 3, 2, 0, 64'h0, 64'h0, 1'b0);

        stall_fetch(5);
        run_bundle(rnd_bundle(), 2, 3, 0, 64'h0, 64'h0, 1'b0);
        chk("fetch_after_release", fetch_wait, 0);

        run_bundle(rnd_bundle(), 2, 300, 0, 64'h0, 64'h0, 1'b0);
        run_bundle(rnd_bundle(), 1, 2, 0, 64'h0, 64'h0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                stall_fetch($urandom_range(1, 4));
                run_bundle(rnd_bundle(), $urandom_range(0, 3),
                           $urandom_range(2, 8), $urandom_range(0, 2),
                           {$urandom, $urandom}, {$urandom, $urandom},
                           1'($urandom_range(0, 1)));
                chk("rand_stall_release", fetch_wait, 0);
            end else begin
                run_bundle(rnd_bundle(), $urandom_range(0, 3),
                           $urandom_range(2, 8), $urandom_range(0, 2),
                           {$urandom, $urandom}, {$urandom, $urandom},
                           1'($urandom_range(0, 1)));
            end
        end

        n = 0;
        step();
        while (bus.fetch_req !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        bus.fetch_bundle = rnd_bundle();
        bus.fetch_valid  = 1'b1;
        n = 0;
        step();
        while (bus.fu_ready === 4'b0000 && n < 60) begin
            step();
            n++;
        end
        chk("rst_test_issue", bus.fu_ready, 4'hF);
        step();
        bus.fu_working     = 4'b0100;
        bus.redirect_addr  = 64'h9000;
        bus.redirect_valid = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        check_reset_values();
        rst = 1'b0;
        bus.fu_working = 4'b0000;
        exp_pc  = RPC;
        exp_cnt = 32'h0;
        exp_err = 1'b0;
        run_bundle(rnd_bundle(), 2, 3, 0, 64'h0, 64'h0, 1'b0);
        chk("fetch_after_rst", fetch_wait, 0);
        run_bundle(rnd_bundle(), 2, 3, 0, 64'h0, 64'h0, 1'b0);
        step();
        chk("count_after_rst", bus.bundle_count, exp_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=done");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bundle_issue_ctrl.md
Name: bundle_issue_ctrl

Overview:
- Front-end sequencer for the VLIW core.
- Fetches one bundle (NUM_FU x 32-bit slots), broadcasts slot i to functional unit i with a one-cycle instructionReady pulse, then waits for every unit to drain.
- Advances the bundle PC by a fixed stride, or to a pending redirect target.
- Owns the global stall fan-out to all functional units.

Parameters:
- NUM_FU, 4, number of functional units / instruction slots per bundle (power of two, 2..8).
- RESET_PC, 64'h0, bundle address loaded on reset.
- DRAIN_TIMEOUT, 255, max DRAIN cycles before the sticky timeout error is set.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fetch_req  out  1  one-cycle bundle fetch request
- fetch_addr  out  64  bundle address, valid while fetch_req=1
- fetch_valid  in  1  fetch_bundle valid this cycle
- fetch_bundle  in  NUM_FU*32  slot i = bits [32i+31:32i]
- fu_instruction  out  NUM_FU*32  per-unit instruction, held stable from ISSUE until next ISSUE
- fu_ready  out  NUM_FU  per-unit instructionReady pulse
- fu_bundle_addr  out  64  address of the bundle currently issued
- fu_working  in  NUM_FU  per-unit busy flags
- stall_in  in  1  global stall request
- fu_do_stall  out  1  registered copy of stall_in to all units
- redirect_valid  in  1  branch redirect strobe
- redirect_addr  in  64  redirect target
- bundle_count  out  32  retired bundle counter
- timeout_err  out  1  sticky drain-timeout flag

Behaviour:
- Reset (rst=1 at posedge), all outputs registered:
  - state=FETCH, pc=RESET_PC, fetch_req=0, fetch_addr=0, fu_ready=0, fu_instruction=0, fu_bundle_addr=0.
  - fu_do_stall=0, bundle_count=0, timeout_err=0, redirect pending cleared.
  - Reset mid-operation abandons the current bundle; no partial count increment.
- Stride: STRIDE = NUM_FU*4 bytes.
- Redirect alignment: redirect_addr is aligned by clearing its low log2(STRIDE) bits.
- fu_do_stall <= stall_in every cycle (1-cycle latency).
- FSM states: FETCH, WAIT_FETCH, ISSUE, DRAIN.
- FETCH:
  - If stall_in=0: fetch_req=1 and fetch_addr=pc for exactly one cycle, then go to WAIT_FETCH.
  - If stall_in=1: remain in FETCH with fetch_req=0.
- WAIT_FETCH:
  - fetch_req=0.
  - On fetch_valid=1: latch fetch_bundle, go to ISSUE.
  - fetch_valid outside WAIT_FETCH is ignored.
- ISSUE:
  - Entered only if stall_in=0; otherwise hold with fu_ready=0.
  - On the issue cycle: fu_ready = all ones for exactly one cycle, fu_instruction = latched slots, fu_bundle_addr = pc.
  - Load settle counter = 2, go to DRAIN.
- DRAIN:
  - fu_ready=0.
  - Decrement settle while nonzero; fu_working is ignored while settle != 0, to cover the units' registered working flag lag.
  - Once settle=0 and fu_working == 0 for all units:
    - bundle_count += 1 (wraps at 2^32).
    - pc <= pending ? aligned redirect target : pc + STRIDE (64-bit wrap).
    - Clear pending, go to FETCH.
  - Drain cycle counter saturates. On reaching DRAIN_TIMEOUT: set timeout_err (sticky until rst) and keep waiting; no forced exit.
- Redirect handling:
  - redirect_valid in any state latches the target and sets pending.
  - A later redirect before consumption overwrites the earlier one.
  - A redirect in the same cycle as the DRAIN exit is applied at that exit.
- stall_in during DRAIN has no effect on the FSM; units freeze themselves via fu_do_stall.

Test Plan:
1. Reset, RESET_PC=0x1000, NUM_FU=4, memory returns a bundle 2 cycles after each fetch_req, fu_working pulses 3 cycles per issue -> fetch_addr sequence 0x1000, 0x1010, 0x1020; fu_ready pulses are exactly one cycle wide with value 4'b1111; bundle_count=3 after the third drain.
2. Bundle {0xDEADBEEF, 0x0000003F, 0x12345678, 0x00000001} -> fu_instruction slot 0=0x00000001 … slot 3=0xDEADBEEF; slots stay stable through DRAIN; fu_bundle_addr equals the fetched address.
3. redirect_valid=1 with redirect_addr=0x2007 during DRAIN of bundle 0x1000 -> next fetch_addr=0x2000, not 0x1010. Two redirects (0x3000 then 0x4000) in one bundle -> next fetch_addr=0x4000.
4. stall_in=1 for 5 cycles in FETCH -> fetch_req stays 0 for 5 cycles; fu_do_stall is high for 5 cycles, delayed 1 cycle; the fetch proceeds on the cycle after release.
5. One unit holds fu_working=1 for 300 cycles, DRAIN_TIMEOUT=255 -> timeout_err rises after 255 DRAIN cycles and stays high; the FSM exits normally when working drops; timeout_err clears only on rst.
6. rst asserted while in DRAIN with fu_working=1 -> next cycle state=FETCH, pc=RESET_PC, bundle_count=0, fu_ready=0, fetch_req asserted the following cycle.
